riscv_dift_tag_seq: RTL and testbench
=====================================

Name: riscv_dift_tag_seq

Overview:
Multi-cycle sequencer that runs bulk tag operations (snapshot, load, clear of one tag plane) across the whole register file. It drives the DIFT tag manipulation datapath with TAGRD/TAGSET operators, one register per cycle. It shares the register-file tag ports with the core: the core always wins, and the sequencer stalls.

Parameters:
NREGS, 32, number of architectural registers iterated (index width 5)
FIRST_REG, 1, first register visited; x0 is skipped by default

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  bulk command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  DIFT_SEQ_SNAP / DIFT_SEQ_LOAD / DIFT_SEQ_CLEAR
cmd_plane_i  in  2  tag bit plane for SNAP/LOAD
cmd_mask_i  in  4  plane mask for CLEAR
cmd_data_i  in  32  bit vector for LOAD; bit i = new tag bit of register i
rsp_valid_o  out  1  result available
rsp_ready_i  in  1  result consumed
rsp_data_o  out  32  SNAP vector; zero for LOAD/CLEAR
rsp_err_o  out  1  command rejected or aborted
core_stall_i  in  1  core owns the tag-manipulation unit / RF tag port this cycle
abort_i  in  1  flush/exception; terminate the running command
busy_o  out  1  state != IDLE; ID stage holds tag instructions
rf_raddr_o  out  5  RF tag read address
rf_rtag_i  in  dift_tag_t  RF tag read data (combinational)
rf_we_o  out  1  RF tag write enable
rf_waddr_o  out  5  RF tag write address (= rf_raddr_o)
rf_wtag_o  out  dift_tag_t  = tmu_result_tag_i
tmu_operator_o  out  3  DIFT_OP_TAGRD or DIFT_OP_TAGSET
tmu_operand_a_o  out  32  {24'b0, values[3:0], mask[3:0]}
tmu_operand_b_o  out  32  TAGRD: {28'b0, onehot(plane)}; TAGSET: 0
tmu_operand_a_tag_o  out  dift_tag_t  = rf_rtag_i
tmu_operand_c_tag_o  out  dift_tag_t  = rf_rtag_i
tmu_result_i  in  32  datapath result (TAGRD)
tmu_result_tag_i  in  dift_tag_t  datapath result tag (TAGSET)

Behaviour:
- Reset: state IDLE, idx=FIRST_REG, acc=0. Outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, busy_o=0, rf_we_o=0, all addresses/operands 0.
- FSM IDLE -> RUN -> DONE -> IDLE. cmd_ready_o=1 only in IDLE.
- IDLE: on cmd_valid_i, latch op/plane/mask/data, set idx=FIRST_REG, clear acc.
  - If plane >= DIFT_TAG_SIZE for SNAP/LOAD, go directly to DONE with err=1.
  - Otherwise go to RUN.
- RUN, one step per cycle with core_stall_i=0:
  - rf_raddr_o=idx.
  - SNAP: operator TAGRD; acc[idx] <= (tmu_result_i != 0).
  - LOAD: operator TAGSET; mask=onehot(plane); values=data[idx]<<plane; rf_we_o=1.
  - CLEAR: operator TAGSET; mask=cmd_mask; values=0; rf_we_o=1.
  - idx increments after each step.
  - After the step at idx=NREGS-1, go to DONE.
- Stall: while core_stall_i=1, rf_we_o=0, idx and acc hold, and no operand is consumed. Stall is checked every cycle, including the first RUN cycle.
- Latency with no stalls: accept edge + (NREGS-FIRST_REG) RUN cycles, then rsp_valid_o=1. Default is 31 RUN cycles.
- abort_i in RUN, highest priority over stall and step:
  - No write that cycle; go to DONE with err=1.
  - Registers already written keep their new tags; rsp_data_o=0.
- abort_i outside RUN is ignored.
- DONE: rsp_valid_o=1; rsp_data_o=acc for SNAP, else 0; rsp_err_o per flags. Hold until rsp_ready_i, then go to IDLE. A new command is accepted no earlier than the following cycle.
- acc bits below FIRST_REG are always 0.
- Reset asserted mid-RUN: return to IDLE immediately (asynchronous); rf_we_o=0. No response is produced.
- Outside RUN, operator=TAGRD and operands=0 so the datapath stays benign.

Decomposition:
- riscv_defines (shared package):
  - dift_tag_t
  - DIFT_OP_TAGSET / DIFT_OP_TAGRD
  - new DIFT_SEQ_SNAP=2'd0, DIFT_SEQ_LOAD=2'd1, DIFT_SEQ_CLEAR=2'd2 (2'd3 rejected with err)
  - seq state enum
- Operand encoding (mask/values packing) goes in a small combinational sub-module, riscv_dift_seq_opgen. The FSM, counter and accumulator stay in the top.

Test Plan:
- SNAP plane0, tags x1=1, x5=1, x31=1, others 0, no stalls -> rsp after 31 RUN cycles, rsp_data_o=32'h8000_0022, err=0.
- LOAD plane0, data=32'hA5A5_A5A4 -> x2 tag=1, x1 tag=0, x31 tag=1; 31 writes; rf_we_o never asserted for x0; rsp_data_o=0.
- CLEAR mask=4'hF (DIFT_TAG_SIZE=4), all tags 4'hF -> all x1..x31 read back 0; stall 3 cycles mid-run (idx=10) -> idx held, total latency 34 cycles, no write during stall.
- SNAP plane=2 with DIFT_TAG_SIZE=1 -> no RUN cycles, rsp_err_o=1 the cycle after accept; cmd_op=2'd3 -> same.
- LOAD all-ones, abort_i at idx=8 -> x1..x7 written, x8..x31 unchanged, rsp_err_o=1.
- rst pulse during RUN at idx=15 -> rf_we_o=0 at once, cmd_ready_o=1, rsp_valid_o=0; a following SNAP completes normally.

Source files
------------

// File: rtl/riscv_dift_tag_seq_pkg.sv
// rtl/riscv_dift_tag_seq_pkg.sv - shared DIFT tag types, operator codes and sequencer encodings
package riscv_dift_tag_seq_pkg;

    localparam int DIFT_TAG_SIZE = 4;
    localparam int IDX_W         = 5;

    typedef logic [DIFT_TAG_SIZE-1:0] dift_tag_t;

    localparam logic [2:0] DIFT_OP_TAGRD  = 3'd0;
    localparam logic [2:0] DIFT_OP_TAGSET = 3'd1;

    localparam logic [1:0] DIFT_SEQ_SNAP  = 2'd0;
    localparam logic [1:0] DIFT_SEQ_LOAD  = 2'd1;
    localparam logic [1:0] DIFT_SEQ_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    function automatic dift_tag_t plane_onehot(input logic [1:0] plane);
        plane_onehot = dift_tag_t'(1) << plane;
    endfunction

endpackage

// File: rtl/riscv_dift_tag_seq_if.sv
// rtl/riscv_dift_tag_seq_if.sv - bulk command / response handshake bundle
interface riscv_dift_tag_seq_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_plane;
    logic [3:0]  cmd_mask;
    logic [31:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_plane, cmd_mask, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_plane, cmd_mask, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/riscv_dift_seq_opgen.sv
// rtl/riscv_dift_seq_opgen.sv - packs TAGRD/TAGSET operator and mask/value operands for one step
module riscv_dift_seq_opgen
    import riscv_dift_tag_seq_pkg::*;
(
    input  logic        i_active,
    input  logic [1:0]  i_op,
    input  logic [1:0]  i_plane,
    input  logic [3:0]  i_mask,
    input  logic        i_data_bit,
    output logic [2:0]  o_operator,
    output logic [31:0] o_operand_a,
    output logic [31:0] o_operand_b
);

    dift_tag_t w_mask;
    dift_tag_t w_values;

    // Idle or unknown op leaves a harmless TAGRD with zero operands on the datapath
    always_comb begin
        o_operator  = DIFT_OP_TAGRD;
        o_operand_a = '0;
        o_operand_b = '0;
        w_mask      = '0;
        w_values    = '0;
        if (i_active) begin
            case (i_op)
                DIFT_SEQ_SNAP: begin
                    o_operand_b = {28'b0, plane_onehot(i_plane)};
                end
                DIFT_SEQ_LOAD: begin
                    o_operator  = DIFT_OP_TAGSET;
                    w_mask      = plane_onehot(i_plane);
                    w_values    = dift_tag_t'(i_data_bit) << i_plane;
                    o_operand_a = {24'b0, w_values, w_mask};
                end
                DIFT_SEQ_CLEAR: begin
                    o_operator  = DIFT_OP_TAGSET;
                    w_mask      = i_mask;
                    o_operand_a = {24'b0, w_values, w_mask};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riscv_dift_tag_seq.sv
// rtl/riscv_dift_tag_seq.sv - bulk snapshot/load/clear sequencer over the register-file tag plane
module riscv_dift_tag_seq
    import riscv_dift_tag_seq_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int FIRST_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_dift_tag_seq_if.slave    s_bus,
    input  logic                   core_stall_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic [IDX_W-1:0]       rf_raddr_o,
    input  dift_tag_t              rf_rtag_i,
    output logic                   rf_we_o,
    output logic [IDX_W-1:0]       rf_waddr_o,
    output dift_tag_t              rf_wtag_o,
    output logic [2:0]             tmu_operator_o,
    output logic [31:0]            tmu_operand_a_o,
    output logic [31:0]            tmu_operand_b_o,
    output dift_tag_t              tmu_operand_a_tag_o,
    output dift_tag_t              tmu_operand_c_tag_o,
    input  logic [31:0]            tmu_result_i,
    input  dift_tag_t              tmu_result_tag_i
);

    localparam logic [IDX_W-1:0] C_FIRST = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(NREGS - 1);

    seq_state_e       r_state;
    seq_state_e       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_acc;
    logic [1:0]       r_op;
    logic [1:0]       r_plane;
    logic [3:0]       r_mask;
    logic [31:0]      r_data;
    logic             r_err;

    logic             w_run;
    logic             w_step;
    logic             w_cmd_bad;

    assign w_run  = (r_state == SEQ_RUN);
    // Abort outranks a step; stall only freezes the step
    assign w_step = w_run && !abort_i && !core_stall_i;

    assign w_cmd_bad = (s_bus.cmd_op == 2'd3) ||
                       ((s_bus.cmd_op != DIFT_SEQ_CLEAR) && (int'(s_bus.cmd_plane) >= DIFT_TAG_SIZE));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SEQ_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state     = r_state;
        s_bus.cmd_ready  = 1'b0;
        s_bus.rsp_valid  = 1'b0;
        busy_o           = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                s_bus.cmd_ready = 1'b1;
                if (s_bus.cmd_valid) w_next_state = w_cmd_bad ? SEQ_DONE : SEQ_RUN;
            end
            SEQ_RUN: begin
                busy_o = 1'b1;
                if (abort_i)                               w_next_state = SEQ_DONE;
                else if (!core_stall_i && r_idx == C_LAST) w_next_state = SEQ_DONE;
            end
            SEQ_DONE: begin
                busy_o          = 1'b1;
                s_bus.rsp_valid = 1'b1;
                if (s_bus.rsp_ready) w_next_state = SEQ_IDLE;
            end
            default: w_next_state = SEQ_IDLE;
        endcase
    end

    // Command latch, register index walk and snapshot accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= C_FIRST;
            r_acc   <= '0;
            r_op    <= DIFT_SEQ_SNAP;
            r_plane <= '0;
            r_mask  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (s_bus.cmd_valid) begin
                        r_op    <= s_bus.cmd_op;
                        r_plane <= s_bus.cmd_plane;
                        r_mask  <= s_bus.cmd_mask;
                        r_data  <= s_bus.cmd_data;
                        r_idx   <= C_FIRST;
                        r_acc   <= '0;
                        r_err   <= w_cmd_bad;
                    end
                end
                SEQ_RUN: begin
                    if (abort_i) begin
                        r_err <= 1'b1;
                    end else if (!core_stall_i) begin
                        if (r_op == DIFT_SEQ_SNAP) r_acc[r_idx] <= (tmu_result_i != 32'd0);
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    riscv_dift_seq_opgen u_opgen (
        .i_active    (w_run),
        .i_op        (r_op),
        .i_plane     (r_plane),
        .i_mask      (r_mask),
        .i_data_bit  (r_data[r_idx]),
        .o_operator  (tmu_operator_o),
        .o_operand_a (tmu_operand_a_o),
        .o_operand_b (tmu_operand_b_o)
    );

    assign rf_raddr_o          = w_run ? r_idx : '0;
    assign rf_waddr_o          = rf_raddr_o;
    assign rf_we_o             = w_step && (r_op != DIFT_SEQ_SNAP);
    assign rf_wtag_o           = tmu_result_tag_i;
    assign tmu_operand_a_tag_o = w_run ? rf_rtag_i : '0;
    assign tmu_operand_c_tag_o = w_run ? rf_rtag_i : '0;

    // An aborted or rejected command never reports a partial snapshot
    assign s_bus.rsp_data = (r_state == SEQ_DONE && r_op == DIFT_SEQ_SNAP && !r_err) ? r_acc : 32'd0;
    assign s_bus.rsp_err  = (r_state == SEQ_DONE) && r_err;

endmodule

// File: tb/tb_riscv_dift_tag_seq.sv
// tb/tb_riscv_dift_tag_seq.sv - scoreboard bench for the DIFT bulk tag sequencer
module tb_riscv_dift_tag_seq;
    import riscv_dift_tag_seq_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_stall;
    logic        abort;
    logic        busy;
    logic [4:0]  raddr;
    logic [4:0]  waddr;
    dift_tag_t   rtag;
    dift_tag_t   wtag;
    logic        we;
    logic [2:0]  oper;
    logic [31:0] opa;
    logic [31:0] opb;
    dift_tag_t   atag;
    dift_tag_t   ctag;
    logic [31:0] tres;
    dift_tag_t   trestag;

    dift_tag_t   rf_tags  [32];
    dift_tag_t   pre_tags [32];
    dift_tag_t   exp_tags [32];
    logic        pre_load;
    int          n_writes    = 0;
    int          n_x0_writes = 0;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    riscv_dift_tag_seq_if bus ();

    riscv_dift_tag_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_bus               (bus),
        .core_stall_i        (core_stall),
        .abort_i             (abort),
        .busy_o              (busy),
        .rf_raddr_o          (raddr),
        .rf_rtag_i           (rtag),
        .rf_we_o             (we),
        .rf_waddr_o          (waddr),
        .rf_wtag_o           (wtag),
        .tmu_operator_o      (oper),
        .tmu_operand_a_o     (opa),
        .tmu_operand_b_o     (opb),
        .tmu_operand_a_tag_o (atag),
        .tmu_operand_c_tag_o (ctag),
        .tmu_result_i        (tres),
        .tmu_result_tag_i    (trestag)
    );

    // Register-file tag plane and tag-manipulation unit models
    assign rtag = rf_tags[raddr];

    always_comb begin
        tres    = (oper == DIFT_OP_TAGRD) ? {28'b0, atag & opb[3:0]} : 32'd0;
        trestag = (atag & ~opa[3:0]) | (opa[7:4] & opa[3:0]);
    end

    always @(posedge clk) begin
        if (pre_load) begin
            rf_tags <= pre_tags;
        end else if (we) begin
            rf_tags[waddr] <= wtag;
            n_writes <= n_writes + 1;
            if (waddr == 5'd0) n_x0_writes <= n_x0_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_preload();
        pre_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pre_load = 1'b0;
    endtask

    task automatic check_rf(input string name);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_x%0d", name, i), rf_tags[i], exp_tags[i]);
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [1:0] plane,
                           input logic [3:0] mask, input logic [31:0] data,
                           input int stall_at, input int abort_at,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_cycles, input int exp_writes);
        exp_t e;
        int   n;
        int   stalls;
        int   w0;
        int   wx0;
        bit   done;
        e.data = exp_data; e.err = exp_err; e.cycles = exp_cycles;
        check({name, "_cmd_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_plane = plane;
        bus.cmd_mask = mask; bus.cmd_data = data;
        sb.push_back(e);
        w0 = n_writes; wx0 = n_x0_writes;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0; stalls = 0; done = 1'b0;
        while (!done && n < 200) begin
            if (bus.rsp_valid) begin
                done = 1'b1;
            end else begin
                n++;
                if (int'(raddr) == stall_at && stalls < 3) begin
                    core_stall = 1'b1;
                    stalls++;
                    #1 check({name, "_stall_we"}, we, 0);
                end else begin
                    core_stall = 1'b0;
                end
                if (int'(raddr) == abort_at) begin
                    abort = 1'b1;
                    #1 check({name, "_abort_we"}, we, 0);
                end else begin
                    abort = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        core_stall = 1'b0;
        abort      = 1'b0;
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({name, "_rsp_data"}, bus.rsp_data, e.data);
            check({name, "_rsp_err"}, bus.rsp_err, e.err);
            check({name, "_latency"}, n, e.cycles);
            @(posedge clk);
            @(negedge clk);
            check({name, "_rsp_hold"}, {bus.rsp_valid, bus.rsp_data}, {1'b1, e.data});
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            check({name, "_back_idle"}, {busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
        end
        check({name, "_writes"}, n_writes - w0, exp_writes);
        check({name, "_x0_writes"}, n_x0_writes - wx0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; core_stall = 1'b0; abort = 1'b0; pre_load = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_plane = '0;
        bus.cmd_mask = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) pre_tags[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_handshake", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy, we}, 5'b10000);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_addr_op", {raddr, waddr, oper, opa, opb}, {5'd0, 5'd0, DIFT_OP_TAGRD, 64'd0});
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {bus.cmd_ready, busy, we, raddr}, {3'b100, 5'd0});

        // SNAP plane0 / plane1 over a sparse tag pattern
        for (int i = 0; i < 32; i++) pre_tags[i] = '0;
        pre_tags[0] = 4'b0001; pre_tags[1] = 4'b0001; pre_tags[5] = 4'b0001;
        pre_tags[31] = 4'b0001; pre_tags[3] = 4'b0010; pre_tags[7] = 4'b1110;
        do_preload();
        run_cmd("snap_p0", DIFT_SEQ_SNAP, 2'd0, 4'h0, 32'h0, -1, -1, 32'h8000_0022, 1'b0, 31, 0);
        run_cmd("snap_p1", DIFT_SEQ_SNAP, 2'd1, 4'h0, 32'h0, -1, -1, 32'h0000_0088, 1'b0, 31, 0);

        // LOAD plane0
        for (int i = 0; i < 32; i++) pre_tags[i] = 4'b1010;
        do_preload();
        run_cmd("load_p0", DIFT_SEQ_LOAD, 2'd0, 4'h0, 32'hA5A5_A5A4, -1, -1, 32'h0, 1'b0, 31, 31);
        begin
            logic [31:0] d;
            d = 32'hA5A5_A5A4;
            for (int i = 0; i < 32; i++)
                exp_tags[i] = (i == 0) ? 4'b1010 : ((4'b1010 & 4'b1110) | {3'b0, d[i]});
        end
        check_rf("load_p0");

        // LOAD plane3
        for (int i = 0; i < 32; i++) pre_tags[i] = 4'b0101;
        do_preload();
        run_cmd("load_p3", DIFT_SEQ_LOAD, 2'd3, 4'h0, 32'h0000_F00F, -1, -1, 32'h0, 1'b0, 31, 31);
        begin
            logic [31:0] d;
            d = 32'h0000_F00F;
            for (int i = 0; i < 32; i++)
                exp_tags[i] = (i == 0) ? 4'b0101 : {d[i], 3'b101};
        end
        check_rf("load_p3");

        // CLEAR all planes with a 3-cycle stall at x10
        for (int i = 0; i < 32; i++) pre_tags[i] = 4'hF;
        do_preload();
        run_cmd("clear_f", DIFT_SEQ_CLEAR, 2'd0, 4'hF, 32'h0, 10, -1, 32'h0, 1'b0, 34, 31);
        for (int i = 0; i < 32; i++) exp_tags[i] = (i == 0) ? 4'hF : 4'h0;
        check_rf("clear_f");

        // CLEAR middle planes only
        do_preload();
        run_cmd("clear_6", DIFT_SEQ_CLEAR, 2'd0, 4'h6, 32'h0, -1, -1, 32'h0, 1'b0, 31, 31);
        for (int i = 0; i < 32; i++) exp_tags[i] = (i == 0) ? 4'hF : 4'h9;
        check_rf("clear_6");

        // Illegal op is rejected without any RUN cycle
        run_cmd("bad_op", 2'd3, 2'd0, 4'h0, 32'h0, -1, -1, 32'h0, 1'b1, 0, 0);

        // LOAD all-ones aborted at x8
        for (int i = 0; i < 32; i++) pre_tags[i] = 4'h0;
        do_preload();
        run_cmd("abort", DIFT_SEQ_LOAD, 2'd1, 4'h0, 32'hFFFF_FFFF, -1, 8, 32'h0, 1'b1, 8, 7);
        for (int i = 0; i < 32; i++) exp_tags[i] = (i >= 1 && i <= 7) ? 4'b0010 : 4'b0000;
        check_rf("abort");

        // Reset mid-LOAD at x15, then a clean SNAP of what was written
        do_preload();
        bus.cmd_valid = 1'b1; bus.cmd_op = DIFT_SEQ_LOAD; bus.cmd_plane = 2'd0;
        bus.cmd_mask = 4'h0; bus.cmd_data = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (raddr != 5'd15 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_run_idx", raddr, 15);
        rst = 1'b1;
        #1;
        check("rst_run_outputs", {we, bus.cmd_ready, bus.rsp_valid, busy}, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_no_rsp", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        check("rst_run_sb_empty", sb.size(), 0);
        run_cmd("snap_after_rst", DIFT_SEQ_SNAP, 2'd0, 4'h0, 32'h0, -1, -1, 32'h0000_7FFE, 1'b0, 31, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
